// File: rtl/regression_sample_feeder.sv
// regression_sample_feeder: buffers one batch of N (x,y) samples and streams it to the XTX/XTY accumulators; FEEDER_AUTOSTART_EN starts streaming when the buffer fills
module regression_sample_feeder #(
  parameter int N  = 256,
  parameter int W  = 12,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_x,
  input  logic [W-1:0]  wr_y,
  output logic          wr_ready,
  output logic [AW:0]   fill,
  input  logic          go,
  output logic          acc_start,
  output logic [W-1:0]  xi,
  output logic [W-1:0]  yi,
  input  logic          xtx_valid,
  input  logic          xty_valid,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {FILL, START, STREAM, WAIT} state_t;
  localparam logic [AW:0] FULL = (AW+1)'(N);
  localparam logic [AW:0] LAST = (AW+1)'(N-1);
  state_t state, state_nx;
  logic [W-1:0] mem_x [N];
  logic [W-1:0] mem_y [N];
  logic [AW:0] fill_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic [W-1:0] xi_nx, yi_nx;
  logic fx, fy, fx_nx, fy_nx;
  logic wr_acc, start_req, both;
  logic wr_ready_nx, acc_start_nx, busy_nx, done_nx;
  assign wr_acc = wr_en && wr_ready;
  assign both = (fx || xtx_valid) && (fy || xty_valid);
`ifdef FEEDER_AUTOSTART_EN
  logic unused_go;
  assign unused_go = go;
  assign start_req = wr_acc && fill == LAST;
`else
  assign start_req = go && fill == FULL;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FILL;
    else state <= state_nx;
  always_comb
    state_nx = state == FILL   ? (start_req ? START : FILL) :
               state == START  ? STREAM :
               state == STREAM ? (ptr == '0 ? WAIT : STREAM) :
                                 (both ? FILL : WAIT);
  // ptr holds the index of the next sample to present; wrapping to 0 marks the end of the batch
  always_comb begin
    fill_nx      = (state == WAIT && both) ? '0 : wr_acc ? fill + (AW+1)'(1) : fill;
    ptr_nx       = state == START ? AW'(1) : state == STREAM ? ptr + AW'(1) : '0;
    xi_nx        = state == START ? mem_x[0] : (state == STREAM && ptr != '0) ? mem_x[ptr] : '0;
    yi_nx        = state == START ? mem_y[0] : (state == STREAM && ptr != '0) ? mem_y[ptr] : '0;
    fx_nx        = (state == WAIT && !both) ? (fx || xtx_valid) : 1'b0;
    fy_nx        = (state == WAIT && !both) ? (fy || xty_valid) : 1'b0;
    acc_start_nx = state_nx == START;
    busy_nx      = state_nx != FILL;
    done_nx      = state == WAIT && both;
    wr_ready_nx  = state_nx == FILL && fill_nx < FULL;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fill      <= '0;
      ptr       <= '0;
      xi        <= '0;
      yi        <= '0;
      fx        <= 1'b0;
      fy        <= 1'b0;
      acc_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_ready  <= 1'b1;
    end else begin
      fill      <= fill_nx;
      ptr       <= ptr_nx;
      xi        <= xi_nx;
      yi        <= yi_nx;
      fx        <= fx_nx;
      fy        <= fy_nx;
      acc_start <= acc_start_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      wr_ready  <= wr_ready_nx;
    end
  always_ff @(posedge clk)
    if (wr_acc) begin
      mem_x[fill[AW-1:0]] <= wr_x;
      mem_y[fill[AW-1:0]] <= wr_y;
    end
endmodule

// File: tb/tb_regression_sample_feeder.sv
// tb_regression_sample_feeder: randomized batches checked against a queue-based model of the feeder
module tb_regression_sample_feeder;
  localparam int N  = 256;
  localparam int W  = 12;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic rst_n, wr_en, go, xtx_valid, xty_valid;
  logic [W-1:0] wr_x, wr_y;
  logic wr_ready, acc_start, busy, done;
  logic [AW:0] fill;
  logic [W-1:0] xi, yi;
  logic [W-1:0] qx[$];
  logic [W-1:0] qy[$];
  int mfill = 0;
  int n_cmp = 0;
  int n_bad = 0;
  regression_sample_feeder #(.N(N), .W(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_ready(wr_ready), .fill(fill), .go(go), .acc_start(acc_start),
    .xi(xi), .yi(yi), .xtx_valid(xtx_valid), .xty_valid(xty_valid),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic model_clear();
    qx.delete();
    qy.delete();
    mfill = 0;
  endtask
  task automatic wr(input logic [W-1:0] x, input logic [W-1:0] y);
    wr_en = 1'b1;
    wr_x = x;
    wr_y = y;
    step();
    wr_en = 1'b0;
    if (mfill < N) begin
      qx.push_back(x);
      qy.push_back(y);
      mfill++;
    end
    chk("fill", 32'(fill), 32'(mfill));
  endtask
  task automatic fill_batch(input int from, input int upto, input bit ramp);
    for (int i = from; i < upto; i++) begin
      if (!ramp && $urandom_range(0, 3) == 0) step();
      wr(ramp ? W'(i) : W'($urandom), ramp ? W'(2 * i) : W'($urandom));
    end
  endtask
  task automatic pulse(input logic vx, input logic vy);
    xtx_valid = vx;
    xty_valid = vy;
    step();
    xtx_valid = 1'b0;
    xty_valid = 1'b0;
  endtask
  task automatic do_go(input int abort_k);
`ifndef FEEDER_AUTOSTART_EN
    go = 1'b1;
    step();
    go = 1'b0;
`endif
    chk("acc_start_hi", 32'(acc_start), 1);
    chk("busy_start", 32'(busy), 1);
    step();
    chk("acc_start_lo", 32'(acc_start), 0);
    for (int k = 0; k < N; k++) begin
      chk("xi", 32'(xi), 32'(qx[k]));
      chk("yi", 32'(yi), 32'(qy[k]));
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        chk("abort_xi", 32'(xi), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_fill", 32'(fill), 0);
        chk("abort_ready", 32'(wr_ready), 1);
        model_clear();
        step();
        rst_n = 1'b1;
        step();
        return;
      end
      step();
    end
    chk("xi_idle", 32'(xi), 0);
    chk("yi_idle", 32'(yi), 0);
    chk("busy_wait", 32'(busy), 1);
    chk("done_early", 32'(done), 0);
  endtask
  task automatic expect_done();
    chk("done_hi", 32'(done), 1);
    chk("fill_clr", 32'(fill), 0);
    chk("ready_back", 32'(wr_ready), 1);
    chk("busy_lo", 32'(busy), 0);
    model_clear();
    step();
    chk("done_lo", 32'(done), 0);
  endtask
  initial begin
    rst_n = 1'b0;
    {wr_en, go, xtx_valid, xty_valid} = '0;
    wr_x = '0;
    wr_y = '0;
    step();
    chk("rst_acc_start", 32'(acc_start), 0);
    chk("rst_xi", 32'(xi), 0);
    chk("rst_yi", 32'(yi), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    step();
    // ramp batch with an early go and overflow writes
    fill_batch(0, 100, 1'b1);
`ifndef FEEDER_AUTOSTART_EN
    go = 1'b1;
    step();
    go = 1'b0;
    chk("early_go_start", 32'(acc_start), 0);
    chk("early_go_busy", 32'(busy), 0);
    step();
    chk("early_go_start2", 32'(acc_start), 0);
    fill_batch(100, N, 1'b1);
    chk("full_ready", 32'(wr_ready), 0);
    for (int i = 0; i < 10; i++) wr(W'($urandom), W'($urandom));
    chk("ovf_ready", 32'(wr_ready), 0);
    chk("ovf_fill", 32'(fill), N);
`else
    fill_batch(100, N, 1'b1);
`endif
    do_go(-1);
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("stagger_done", 32'(done), 0);
      step();
    end
    chk("stagger_done", 32'(done), 0);
    pulse(1'b0, 1'b1);
    expect_done();
    // stray valids during FILL must not pre-arm the flags
    pulse(1'b1, 1'b1);
    chk("fill_valid_done", 32'(done), 0);
    pulse(1'b1, 1'b0);
    chk("fill_valid_busy", 32'(busy), 0);
    fill_batch(0, N, 1'b0);
    do_go(-1);
    pulse(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("half_done", 32'(done), 0);
      step();
    end
    pulse(1'b1, 1'b0);
    expect_done();
    // abort mid-stream, then a fresh batch with simultaneous valids
    fill_batch(0, N, 1'b0);
    do_go(37);
    chk("post_rst_fill", 32'(fill), 0);
    chk("post_rst_start", 32'(acc_start), 0);
    fill_batch(0, N, 1'b0);
    do_go(-1);
    step();
    pulse(1'b1, 1'b1);
    expect_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
